// File: rtl/link_vc_buffer.sv
// Per-link virtual-channel buffer: one FIFO per VC feeding a registered output
// stage that interleaves VCs round-robin at phit granularity.
module link_vc_buffer #(
    parameter int no_vc                      = 2,
    parameter int floorplusone_log2_no_vc    = 2,
    parameter int phit_size                  = 32,
    parameter int buf_size                   = 4,
    parameter int floorplusone_log2_buf_size = 3
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [phit_size-1:0]               indata,
    input  logic                               insent_req,
    input  logic                               innew,
    input  logic [floorplusone_log2_no_vc-1:0] invc_no,
    output logic                               outready,
    output logic [phit_size-1:0]               outdata,
    output logic                               outsent_req,
    output logic                               outnew,
    output logic [floorplusone_log2_no_vc-1:0] outvc_no,
    input  logic                               inready,
    output logic [no_vc-1:0]                   vc_full_vec,
    output logic                               busy
);
    // Handshake: a phit moves on an edge where the sender's valid (insent_req /
    // outsent_req) and the receiver's ready (outready / inready) are both high.
    // outready depends only on invc_no and registered counts, never on insent_req.

    localparam int ptr_w = (buf_size > 1) ? $clog2(buf_size) : 1;
    localparam int vc_w  = floorplusone_log2_no_vc;
    localparam int cnt_w = floorplusone_log2_buf_size;

    logic [phit_size:0] mem [no_vc][buf_size];
    logic [cnt_w-1:0]   count  [no_vc];
    logic [ptr_w-1:0]   rd_ptr [no_vc];
    logic [ptr_w-1:0]   wr_ptr [no_vc];
    logic [vc_w-1:0]    rr_ptr;

    logic [no_vc-1:0]   nonempty;
    logic [no_vc-1:0]   push_v;
    logic [no_vc-1:0]   pop_v;
    logic               load_ok;
    logic               found;
    logic [vc_w-1:0]    pick;
    logic [phit_size:0] head;

    function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
        return (p == ptr_w'(buf_size - 1)) ? '0 : p + ptr_w'(1);
    endfunction

    always_comb begin
        for (int v = 0; v < no_vc; v++) begin
            nonempty[v]    = (count[v] != '0);
            vc_full_vec[v] = (count[v] == cnt_w'(buf_size));
        end
    end

    assign busy = (|nonempty) | outsent_req;

    // VC numbers at or above no_vc never match, so outready stays low for them.
    always_comb begin
        outready = 1'b0;
        for (int v = 0; v < no_vc; v++) begin
            if (invc_no == vc_w'(v)) outready = !vc_full_vec[v];
        end
    end

    always_comb begin
        for (int v = 0; v < no_vc; v++) begin
            push_v[v] = insent_req && outready && (invc_no == vc_w'(v));
        end
    end

    // Search rr_ptr+1, rr_ptr+2, ... and finish with rr_ptr itself.
    always_comb begin
        load_ok = !outsent_req || inready;
        found   = 1'b0;
        pick    = '0;
        for (int k = 1; k <= no_vc; k++) begin
            for (int v = 0; v < no_vc; v++) begin
                if (!found && nonempty[v] && (v == (int'(rr_ptr) + k) % no_vc)) begin
                    found = 1'b1;
                    pick  = vc_w'(v);
                end
            end
        end
        head = '0;
        for (int v = 0; v < no_vc; v++) begin
            pop_v[v] = load_ok && found && (pick == vc_w'(v));
            if (pick == vc_w'(v)) head = mem[v][rd_ptr[v]];
        end
    end

    always_ff @(posedge clk) begin
        for (int v = 0; v < no_vc; v++) begin
            if (push_v[v]) mem[v][wr_ptr[v]] <= {innew, indata};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int v = 0; v < no_vc; v++) begin
                count[v]  <= '0;
                rd_ptr[v] <= '0;
                wr_ptr[v] <= '0;
            end
            rr_ptr      <= '0;
            outsent_req <= 1'b0;
            outnew      <= 1'b0;
            outdata     <= '0;
            outvc_no    <= '0;
        end else begin
            for (int v = 0; v < no_vc; v++) begin
                if (push_v[v]) wr_ptr[v] <= ptr_inc(wr_ptr[v]);
                if (pop_v[v])  rd_ptr[v] <= ptr_inc(rd_ptr[v]);
                if (push_v[v] && !pop_v[v])
                    count[v] <= count[v] + cnt_w'(1);
                else if (!push_v[v] && pop_v[v])
                    count[v] <= count[v] - cnt_w'(1);
            end
            if (load_ok && found) begin
                outdata     <= head[phit_size-1:0];
                outnew      <= head[phit_size];
                outvc_no    <= pick;
                outsent_req <= 1'b1;
                rr_ptr      <= pick;
            end else if (outsent_req && inready) begin
                outsent_req <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_link_vc_buffer.sv
// Randomized and directed bench for link_vc_buffer: a queue-based reference model
// predicts every transfer; a separate monitor checks what the DUT actually sends.
module tb_link_vc_buffer;
    localparam int no_vc    = 2;
    localparam int vc_w     = 2;
    localparam int pw       = 32;
    localparam int buf_size = 4;
    localparam int cnt_w    = 3;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [pw-1:0]   indata = '0;
    logic            insent_req = 1'b0;
    logic            innew = 1'b0;
    logic [vc_w-1:0] invc_no = '0;
    logic            outready;
    logic [pw-1:0]   outdata;
    logic            outsent_req;
    logic            outnew;
    logic [vc_w-1:0] outvc_no;
    logic            inready = 1'b0;
    logic [no_vc-1:0] vc_full_vec;
    logic            busy;

    always #5 clk = ~clk;

    link_vc_buffer #(
        .no_vc(no_vc), .floorplusone_log2_no_vc(vc_w), .phit_size(pw),
        .buf_size(buf_size), .floorplusone_log2_buf_size(cnt_w)
    ) dut (
        .clk(clk), .reset(reset), .indata(indata), .insent_req(insent_req),
        .innew(innew), .invc_no(invc_no), .outready(outready), .outdata(outdata),
        .outsent_req(outsent_req), .outnew(outnew), .outvc_no(outvc_no),
        .inready(inready), .vc_full_vec(vc_full_vec), .busy(busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Scoreboard: {vc, new, data} of every phit the model places in the output stage.
    logic [vc_w+pw:0] exp_q [$];

    // Reference model: one queue of {new, data} per VC plus the output stage.
    logic [pw:0]      m_q [no_vc][$];
    logic             m_valid = 1'b0;
    int               m_rr = 0;
    int               m_pick;
    int               m_v;
    logic [no_vc-1:0] m_full;
    logic             m_ordy;
    logic             m_busy;
    logic [pw:0]      m_ph;

    int rr_seq [6] = '{10, 20, 11, 21, 12, 22};
    int rr_vc  [6] = '{0, 1, 0, 1, 0, 1};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model evaluated at the falling edge: compare pre-edge state, then advance
    // to what the next rising edge must produce.
    always @(negedge clk) begin
        if (!reset) begin
            for (int v = 0; v < no_vc; v++) m_q[v].delete();
            exp_q.delete();
            m_valid = 1'b0;
            m_rr    = 0;
        end else begin
            m_busy = m_valid;
            for (int v = 0; v < no_vc; v++) begin
                m_full[v] = (m_q[v].size() == buf_size);
                if (m_q[v].size() > 0) m_busy = 1'b1;
            end
            m_ordy = 1'b0;
            if (int'(invc_no) < no_vc) m_ordy = (m_q[int'(invc_no)].size() < buf_size);
            chk("outready", 64'(outready), 64'(m_ordy));
            chk("vc_full_vec", 64'(vc_full_vec), 64'(m_full));
            chk("busy", 64'(busy), 64'(m_busy));
            chk("outsent_req", 64'(outsent_req), 64'(m_valid));

            if (!m_valid || inready) begin
                m_pick = -1;
                for (int k = 1; k <= no_vc; k++) begin
                    m_v = (m_rr + k) % no_vc;
                    if (m_pick < 0 && m_q[m_v].size() > 0) m_pick = m_v;
                end
                if (m_pick >= 0) begin
                    m_ph = m_q[m_pick].pop_front();
                    exp_q.push_back({vc_w'(m_pick), m_ph});
                    m_valid = 1'b1;
                    m_rr    = m_pick;
                end else begin
                    m_valid = 1'b0;
                end
            end
            if (insent_req && m_ordy) m_q[int'(invc_no)].push_back({innew, indata});
        end
    end

    // Monitor: whenever the stage is valid it must show the oldest predicted phit.
    always @(negedge clk) begin
        if (reset && outsent_req) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 64'(exp_q.size()), 64'd1);
            end else begin
                chk("out_phit", 64'({outvc_no, outnew, outdata}), 64'(exp_q[0]));
                if (inready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_phit(input int vc, input logic nw, input logic [pw-1:0] d);
        int   t;
        logic acc;
        insent_req = 1'b1;
        invc_no    = vc_w'(vc);
        innew      = nw;
        indata     = d;
        t   = 0;
        acc = 1'b0;
        while (!acc && t < 200) begin
            @(negedge clk);
            acc = outready;
            @(posedge clk);
            #1;
            t++;
        end
        insent_req = 1'b0;
        if (!acc) chk("send_timeout", 64'(t), 64'd0);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 300) begin
            step();
            t++;
        end
        if (busy) chk("idle_timeout", 64'(busy), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outsent_req", 64'(outsent_req), 64'd0);
        chk("rst_outnew", 64'(outnew), 64'd0);
        chk("rst_outdata", 64'(outdata), 64'd0);
        chk("rst_outvc_no", 64'(outvc_no), 64'd0);
        chk("rst_vc_full_vec", 64'(vc_full_vec), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        reset = 1'b1;
        step();

        // First phit: visible two edges after the push, gone after the transfer edge.
        inready = 1'b1;
        send_phit(0, 1'b1, 32'hA5A5A5A5);
        chk("t1_busy_after_push", 64'(busy), 64'd1);
        chk("t1_not_yet_valid", 64'(outsent_req), 64'd0);
        step();
        chk("t1_valid", 64'(outsent_req), 64'd1);
        chk("t1_data", 64'(outdata), 64'hA5A5A5A5);
        chk("t1_new", 64'(outnew), 64'd1);
        chk("t1_vc", 64'(outvc_no), 64'd0);
        chk("t1_busy_staged", 64'(busy), 64'd1);
        step();
        chk("t1_valid_after_xfer", 64'(outsent_req), 64'd0);
        chk("t1_busy_after_xfer", 64'(busy), 64'd0);

        // Backpressure: stage holds a vc0 phit while vc1 fills completely.
        inready = 1'b0;
        send_phit(0, 1'b1, 32'h100);
        step();
        for (int i = 1; i <= 4; i++) send_phit(1, i == 1, pw'(i));
        chk("t2_full_vec", 64'(vc_full_vec), 64'b10);
        invc_no = 2'd1;
        #1 chk("t2_ordy_vc1", 64'(outready), 64'd0);
        invc_no = 2'd0;
        #1 chk("t2_ordy_vc0", 64'(outready), 64'd1);
        invc_no = 2'd2;
        #1 chk("t2_ordy_vc2", 64'(outready), 64'd0);
        insent_req = 1'b1;
        invc_no    = 2'd1;
        innew      = 1'b0;
        indata     = 32'd5;
        repeat (4) step();
        insent_req = 1'b0;
        chk("t2_still_full", 64'(vc_full_vec), 64'b10);
        chk("t2_hold_data", 64'(outdata), 64'h100);
        chk("t2_hold_vc", 64'(outvc_no), 64'd0);
        inready = 1'b1;
        wait_idle();

        // Round robin interleave with no bubbles.
        inready = 1'b0;
        for (int i = 0; i < 3; i++) send_phit(0, i == 0, pw'(10 + i));
        for (int i = 0; i < 3; i++) send_phit(1, i == 0, pw'(20 + i));
        step();
        inready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rr_valid", 64'(outsent_req), 64'd1);
            chk("rr_data", 64'(outdata), 64'(rr_seq[i]));
            chk("rr_vc", 64'(outvc_no), 64'(rr_vc[i]));
            @(posedge clk);
            #1;
        end
        wait_idle();

        // Full FIFO with simultaneous drain and upstream pressure.
        inready = 1'b0;
        for (int i = 0; i < 5; i++) send_phit(0, i == 0, pw'(32'h400 + i));
        chk("t4_full_vec", 64'(vc_full_vec), 64'b01);
        inready = 1'b1;
        for (int i = 0; i < 6; i++) send_phit(0, 1'b0, pw'(32'h410 + i));
        wait_idle();

        // Stall stability for five cycles, then exactly one transfer.
        inready = 1'b0;
        send_phit(1, 1'b1, 32'hDEAD0001);
        step();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", 64'(outsent_req), 64'd1);
            chk("stall_data", 64'(outdata), 64'hDEAD0001);
            chk("stall_vc", 64'(outvc_no), 64'd1);
            chk("stall_new", 64'(outnew), 64'd1);
            @(posedge clk);
            #1;
        end
        inready = 1'b1;
        step();
        chk("stall_one_xfer", 64'(outsent_req), 64'd0);
        chk("stall_busy", 64'(busy), 64'd0);

        // Random traffic, including out-of-range VC numbers.
        for (int c = 0; c < 400; c++) begin
            insent_req = 1'($urandom_range(0, 1));
            invc_no    = ($urandom_range(0, 9) == 0) ? vc_w'($urandom_range(2, 3))
                                                     : vc_w'($urandom_range(0, 1));
            innew      = 1'($urandom_range(0, 1));
            indata     = $urandom;
            inready    = ($urandom_range(0, 3) != 0);
            step();
        end
        insent_req = 1'b0;
        inready    = 1'b1;
        wait_idle();

        // Asynchronous reset with phits buffered: outputs clear without an edge.
        inready = 1'b0;
        send_phit(0, 1'b1, 32'hC0);
        send_phit(1, 1'b1, 32'hC1);
        send_phit(0, 1'b0, 32'hC2);
        step();
        #2;
        reset = 1'b0;
        #1;
        chk("arst_outsent_req", 64'(outsent_req), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_vc_full_vec", 64'(vc_full_vec), 64'd0);
        chk("arst_outdata", 64'(outdata), 64'd0);
        chk("arst_outnew", 64'(outnew), 64'd0);
        chk("arst_outvc_no", 64'(outvc_no), 64'd0);
        repeat (2) step();
        reset   = 1'b1;
        inready = 1'b1;
        repeat (6) step();
        chk("post_rst_valid", 64'(outsent_req), 64'd0);
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
